// File: rtl/amm_master_pkg.sv
// Shared types and widths for the Avalon-MM command master.
// Holds the bus widths, the FSM state type and the local command bundle.
package amm_master_pkg;

    localparam int AMM_ADDR_W = 4;
    localparam int AMM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_REQ  = 2'd2,
        READ_WAIT = 2'd3
    } amm_master_state_t;

    typedef struct packed {
        logic                  write;
        logic [AMM_ADDR_W-1:0] address;
        logic [AMM_DATA_W-1:0] writedata;
    } amm_cmd_t;

endpackage

// File: rtl/avalon_mm_if.sv
// Avalon-MM bus bundle shared by the CSR slaves and the command master.
// master: drives address/write/writedata/read; slave: drives waitrequest/readdata/readdatavalid.
interface avalon_mm_if;
    import amm_master_pkg::*;

    logic [AMM_ADDR_W-1:0] address;
    logic                  write;
    logic [AMM_DATA_W-1:0] writedata;
    logic                  read;
    logic                  waitrequest;
    logic [AMM_DATA_W-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/amm_watchdog.sv
// Transaction wait counter: cleared by start_i, counts cycles while run_i.
// Ports: clk_i, srst_i, start_i, run_i in; expired_o high on the LIMIT-th waiting cycle.
module amm_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic start_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_last;

    // The cycle holding LAST is the LIMIT-th waiting cycle; flagging it here
    // lets the master drop the request on the edge the count would reach LIMIT.
    assign at_last   = (cnt == LAST);
    assign expired_o = run_i && at_last;

    always_ff @(posedge clk_i) begin
        if (srst_i || start_i) begin
            cnt <= '0;
        end else if (run_i && !at_last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/amm_cmd_master.sv
// Avalon-MM master: one local valid/ready command -> one bus transaction -> one rsp pulse.
// Ports: clk_i, srst_i (sync, active-high); cmd_* in / cmd_ready_o; rsp_valid_o,
// rsp_readdata_o, rsp_err_o; amm (avalon_mm_if.master). All outputs registered.
// Optional timeout abort: define AMM_MASTER_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module amm_cmd_master
    import amm_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [AMM_ADDR_W-1:0] cmd_address_i,
    input  logic [AMM_DATA_W-1:0] cmd_writedata_i,
    output logic                  rsp_valid_o,
    output logic [AMM_DATA_W-1:0] rsp_readdata_o,
    output logic                  rsp_err_o,
    avalon_mm_if.master           amm
);

    amm_master_state_t state;
    amm_cmd_t          cmd;

    logic accept;
    logic wr_done;
    logic rd_acc;
    logic rd_done;
    logic abort;

    assign cmd = '{
        write:     cmd_write_i,
        address:   cmd_address_i,
        writedata: cmd_writedata_i
    };

    // cmd_ready_o is itself a flop that stays low through the response
    // cycle, so qualifying with it keeps the next accept one cycle later.
    assign accept  = (state == IDLE) && cmd_ready_o && cmd_valid_i;
    assign wr_done = (state == WRITE) && !amm.waitrequest;
    assign rd_acc  = (state == READ_REQ) && !amm.waitrequest;
    assign rd_done = (rd_acc && amm.readdatavalid)
                  || ((state == READ_WAIT) && amm.readdatavalid);

`ifdef AMM_MASTER_TIMEOUT_EN
    logic busy;
    logic wd_run;
    logic wd_expired;

    assign busy   = (state != IDLE);
    assign wd_run = busy && !(wr_done || rd_done);

    amm_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .start_i   (accept),
        .run_i     (wd_run),
        .expired_o (wd_expired)
    );

    // wd_run already excludes completing cycles, so completion wins.
    assign abort = wd_expired;
`else
    // Without the watchdog the parameter has no effect; keep it referenced.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end

    assign abort = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state          <= IDLE;
            cmd_ready_o    <= 1'b1;
            amm.read       <= 1'b0;
            amm.write      <= 1'b0;
            amm.address    <= '0;
            amm.writedata  <= '0;
            rsp_valid_o    <= 1'b0;
            rsp_readdata_o <= '0;
            rsp_err_o      <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= (state == IDLE) && !accept;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        amm.address   <= cmd.address;
                        amm.writedata <= cmd.writedata;
                        amm.write     <= cmd.write;
                        amm.read      <= !cmd.write;
                        state         <= cmd.write ? WRITE : READ_REQ;
                    end
                end

                WRITE: begin
                    if (wr_done) begin
                        amm.write      <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        rsp_readdata_o <= '0;
                        rsp_err_o      <= 1'b0;
                        state          <= IDLE;
                    end else if (abort) begin
                        amm.write      <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        rsp_readdata_o <= '0;
                        rsp_err_o      <= 1'b1;
                        state          <= IDLE;
                    end
                end

                READ_REQ: begin
                    if (rd_done) begin
                        // Zero-latency slave: data arrives with the accept.
                        amm.read       <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        rsp_readdata_o <= amm.readdata;
                        rsp_err_o      <= 1'b0;
                        state          <= IDLE;
                    end else if (abort) begin
                        amm.read       <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        rsp_readdata_o <= '0;
                        rsp_err_o      <= 1'b1;
                        state          <= IDLE;
                    end else if (rd_acc) begin
                        amm.read <= 1'b0;
                        state    <= READ_WAIT;
                    end
                end

                READ_WAIT: begin
                    if (rd_done) begin
                        rsp_valid_o    <= 1'b1;
                        rsp_readdata_o <= amm.readdata;
                        rsp_err_o      <= 1'b0;
                        state          <= IDLE;
                    end else if (abort) begin
                        rsp_valid_o    <= 1'b1;
                        rsp_readdata_o <= '0;
                        rsp_err_o      <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amm_cmd_master.sv
// Self-checking bench for amm_cmd_master: command table + scripted corner cases.
// Slave model and response scoreboard are driven from expected-transaction queues.
module tb_amm_cmd_master;
    import amm_master_pkg::*;

    localparam int TO = 8;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          waits;
        int          lat;
        logic [31:0] rdata;
        bit          abort;
        bit          rsp;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_address = '0;
    logic [31:0] cmd_writedata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_readdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rsp = 0;
    int cyc = 0;

    vec_t bus_q[$];
    vec_t rsp_q[$];
    int   acc_q[$];
    bit   stray = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_mm_if amm();

    amm_cmd_master #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i           (clk),
        .srst_i          (srst),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_write_i     (cmd_write),
        .cmd_address_i   (cmd_address),
        .cmd_writedata_i (cmd_writedata),
        .rsp_valid_o     (rsp_valid),
        .rsp_readdata_o  (rsp_readdata),
        .rsp_err_o       (rsp_err),
        .amm             (amm)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic vec_t mk(bit wr, logic [3:0] a, logic [31:0] d, int w, int l,
                                logic [31:0] rd, bit ab, bit rsp, bit err, int el);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.waits = w; v.lat = l;
        v.rdata = rd; v.abort = ab; v.rsp = rsp;
        v.exp_rd = (wr || ab) ? 32'h0 : rd;
        v.exp_err = err; v.exp_lat = el;
        return v;
    endfunction

    // Slave model: waits/latency/data come from the expected transaction.
    initial begin : slave
        vec_t        cur;
        bit          in_req;
        bit          req;
        int          stall;
        int          rd_cnt;
        logic [31:0] rd_val;
        logic [3:0]  h_addr;
        logic [31:0] h_wd;
        logic        h_wr;
        in_req = 0; stall = 0; rd_cnt = 0; rd_val = '0;
        h_addr = '0; h_wd = '0; h_wr = 1'b0;
        amm.waitrequest = 1'b0;
        amm.readdatavalid = 1'b0;
        amm.readdata = '0;
        forever begin
            @(negedge clk);
            amm.readdatavalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    amm.readdatavalid = 1'b1;
                    amm.readdata = rd_val;
                end
            end
            if (stray) begin
                amm.readdatavalid = 1'b1;
                amm.readdata = 32'h5757_5757;
                stray = 1'b0;
            end
            req = amm.read || amm.write;
            if (req && !in_req) begin
                check("bus_req_expected", 32'(bus_q.size() != 0), 32'd1);
                if (bus_q.size() != 0) begin
                    cur = bus_q.pop_front();
                    in_req = 1;
                    stall = cur.waits;
                    check("bus_write", 32'(amm.write), 32'(cur.wr));
                    check("bus_read", 32'(amm.read), 32'(!cur.wr));
                    check("bus_addr", 32'(amm.address), 32'(cur.addr));
                    if (cur.wr) check("bus_wdata", amm.writedata, cur.wdata);
                    h_addr = amm.address; h_wd = amm.writedata; h_wr = amm.write;
                end
            end else if (req && in_req) begin
                check("hold_addr", 32'(amm.address), 32'(h_addr));
                check("hold_wdata", amm.writedata, h_wd);
                check("hold_write", 32'(amm.write), 32'(h_wr));
            end else if (!req && in_req) begin
                check("bus_drop_is_abort", 32'(cur.abort), 32'd1);
                in_req = 0;
            end
            if (req && in_req) begin
                if (stall > 0) begin
                    amm.waitrequest = 1'b1;
                    stall--;
                end else begin
                    amm.waitrequest = 1'b0;
                    in_req = 0;
                    if (!h_wr) begin
                        if (cur.lat == 0) begin
                            amm.readdatavalid = 1'b1;
                            amm.readdata = cur.rdata;
                        end else begin
                            rd_cnt = cur.lat;
                            rd_val = cur.rdata;
                        end
                    end
                end
            end else begin
                amm.waitrequest = 1'b0;
            end
        end
    end

    // Response scoreboard.
    initial begin : rsp_chk
        vec_t e;
        int   a;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                n_rsp++;
                check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                check("rsp_ready_low", 32'(cmd_ready), 32'd0);
                if (rsp_q.size() != 0) begin
                    e = rsp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    check("rsp_readdata", rsp_readdata, e.exp_rd);
                    check("rsp_err", 32'(rsp_err), 32'(e.exp_err));
                    if (e.exp_lat >= 0)
                        check("rsp_latency", 32'(cyc - a), 32'(e.exp_lat));
                end
            end
        end
    end

    task automatic send_cmd(input vec_t v);
        bit acc;
        int t;
        acc = 0;
        t = 0;
        bus_q.push_back(v);
        if (v.rsp) rsp_q.push_back(v);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_address = v.addr;
        cmd_writedata = v.wdata;
        for (int i = 0; i < 500; i++) begin
            if (cmd_ready) begin
                t = cyc;
                @(posedge clk);
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        check("cmd_accepted", 32'(acc), 32'd1);
        if (acc && v.rsp) acc_q.push_back(t);
        @(negedge clk);
        check("ready_low_busy", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (rsp_q.size() == 0 && bus_q.size() == 0 && cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("drain_in_time", 32'(ok), 32'd1);
    endtask

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[7];
        vec_t v;
        int   r0;

        vecs[0] = mk(1, 4'h3, 32'hDEADBEEF, 0, 0, 32'h0,        0, 1, 0, 2);
        vecs[1] = mk(1, 4'h5, 32'h0000A5A5, 5, 0, 32'h0,        0, 1, 0, 7);
        vecs[2] = mk(0, 4'h1, 32'h0,        0, 1, 32'h12345678, 0, 1, 0, 3);
        vecs[3] = mk(0, 4'h2, 32'h0,        0, 4, 32'hCAFEF00D, 0, 1, 0, 6);
        vecs[4] = mk(0, 4'hF, 32'h0,        2, 0, 32'h0BADF00D, 0, 1, 0, 4);
        vecs[5] = mk(1, 4'hF, 32'hFFFFFFFF, 1, 0, 32'h0,        0, 1, 0, 3);
        vecs[6] = mk(0, 4'h0, 32'h0,        3, 2, 32'h55AA55AA, 0, 1, 0, 7);

        repeat (3) @(negedge clk);
        srst = 1'b0;
        check("rst_read", 32'(amm.read), 32'd0);
        check("rst_write", 32'(amm.write), 32'd0);
        check("rst_address", 32'(amm.address), 32'd0);
        check("rst_writedata", amm.writedata, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_readdata", rsp_readdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            send_cmd(vecs[i]);
            cmd_valid = 1'b0;
            wait_drain();
        end
        @(negedge clk);
        check("readdata_holds", rsp_readdata, 32'h55AA55AA);

        // Back-to-back with cmd_valid held high.
        r0 = n_rsp;
        send_cmd(mk(1, 4'h7, 32'h11111111, 0, 0, 32'h0,        0, 1, 0, 2));
        send_cmd(mk(0, 4'h8, 32'h0,        0, 1, 32'h22222222, 0, 1, 0, 3));
        send_cmd(mk(1, 4'h9, 32'h33333333, 1, 0, 32'h0,        0, 1, 0, 3));
        cmd_valid = 1'b0;
        wait_drain();
        check("b2b_rsp_count", 32'(n_rsp - r0), 32'd3);

        // Stray readdatavalid while idle.
        r0 = n_rsp;
        stray = 1'b1;
        repeat (5) @(negedge clk);
        check("stray_no_rsp", 32'(n_rsp - r0), 32'd0);
        check("stray_ready", 32'(cmd_ready), 32'd1);

        // Reset while in READ_WAIT; the late readdatavalid must be ignored.
        r0 = n_rsp;
        v = mk(0, 4'hB, 32'h0, 0, 6, 32'hDEAD0001, 0, 0, 0, -1);
        send_cmd(v);
        cmd_valid = 1'b0;
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check("rst_mid_read", 32'(amm.read), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        repeat (8) @(negedge clk);
        check("rst_mid_no_rsp", 32'(n_rsp - r0), 32'd0);
        check("rst_mid_ready_late", 32'(cmd_ready), 32'd1);

        send_cmd(mk(0, 4'h4, 32'h0, 0, 1, 32'h0F0F0F0F, 0, 1, 0, 3));
        cmd_valid = 1'b0;
        wait_drain();

`ifdef AMM_MASTER_TIMEOUT_EN
        // Stuck waitrequest: abort after TO waiting cycles, then normal service.
        send_cmd(mk(1, 4'h6, 32'hABCD1234, 1000, 0, 32'h0, 1, 1, 1, TO + 1));
        cmd_valid = 1'b0;
        wait_drain();
        send_cmd(mk(0, 4'h6, 32'h0, 1000, 1, 32'h77777777, 1, 1, 1, TO + 1));
        cmd_valid = 1'b0;
        wait_drain();
        send_cmd(mk(0, 4'hC, 32'h0, 1, 1, 32'h98765432, 0, 1, 0, 4));
        cmd_valid = 1'b0;
        wait_drain();
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
